// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline buffer with valid/ready, optional skid entry, flush, halt and stall counter
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t              r_state;
  occ_t              w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic              r_main_halt;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_halt;
  logic              r_halt_block;
  logic              w_halt_block_nxt;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_xfer) w_state_nxt = ONE;
        ONE: begin
          if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
          else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_xfer) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_halt_block_nxt = flush ? 1'b0 : (r_halt_block | (w_in_xfer & in_halt));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= EMPTY;
      r_halt_block <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_halt_block <= w_halt_block_nxt;
      r_halted     <= r_halted | (w_out_xfer & r_main_halt);
    end
  end

  // Head always drives out_*; skid only fills when the head is stalled and a new bundle lands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main_data <= '0;
      r_main_halt <= 1'b0;
      r_skid_data <= '0;
      r_skid_halt <= 1'b0;
    end else if (flush) begin
      r_main_data <= '0;
      r_main_halt <= 1'b0;
      r_skid_data <= '0;
      r_skid_halt <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main_data <= in_data;
            r_main_halt <= in_halt;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main_data <= in_data;
            r_main_halt <= in_halt;
          end else if (w_in_xfer) begin
            r_skid_data <= in_data;
            r_skid_halt <= in_halt;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main_data <= r_skid_data;
            r_main_halt <= r_skid_halt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      // Registered ready: computed from next-cycle occupancy so it never lags a fill or drain.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_in_ready <= 1'b1;
        else     r_in_ready <= (w_state_nxt != FULL) & !w_halt_block_nxt;
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = !r_halt_block & (!w_out_valid | out_ready);
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  assign out_halt  = r_main_halt;
  assign halted    = r_halted;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule
